// File: rtl/hazard_unit_mp_pkg.sv
// Shared constants for the multi-port hazard unit: forward-select encoding,
// multi-cycle FSM state codes and default parameter values.
package hazard_unit_mp_pkg;

    localparam int unsigned NSRC_DEF         = 4;
    localparam int unsigned NWP_DEF          = 2;
    localparam int unsigned FWD_W_DEF        = 3;
    localparam int unsigned MC_LAT_DEF       = 4;
    localparam int unsigned USE_EXT_DONE_DEF = 0;
    localparam int unsigned CNT_W_DEF        = 16;

    localparam int FWD_RF = 0;

    function automatic int fwd_m_sel(input int p);
        return 1 + 2 * p;
    endfunction

    function automatic int fwd_w_sel(input int p);
        return 2 + 2 * p;
    endfunction

    typedef logic [1:0] mc_state_t;
    localparam mc_state_t ST_IDLE = 2'd0;
    localparam mc_state_t ST_BUSY = 2'd1;
    localparam mc_state_t ST_LAST = 2'd2;

endpackage

// File: rtl/hazard_unit_mp_mc_busy_fsm.sv
// Multi-cycle execute tracker: holds F/D/E and bubbles M while a MUL/DIV
// is in flight, then gives one LAST cycle for the result to move to M.
module mc_busy_fsm
    import hazard_unit_mp_pkg::*;
#(
    parameter int unsigned MC_LAT       = MC_LAT_DEF,
    parameter int unsigned USE_EXT_DONE = USE_EXT_DONE_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic mc_done_i,
    output logic busy_stall_o,
    output logic bubble_m_o,
    output logic mc_busy_o
);

    localparam int unsigned CntW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;

    mc_state_t         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done;

    assign done = (USE_EXT_DONE != 0) ? mc_done_i : (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_BUSY;
                    cnt_d   = CntW'(MC_LAT - 2);
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                if (done) state_d = ST_LAST;
            end
            // start_i here still belongs to the finishing instruction
            ST_LAST: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_stall_o = (state_q == ST_BUSY);
    assign bubble_m_o   = (state_q == ST_BUSY);
    assign mc_busy_o    = (state_q != ST_IDLE);

endmodule

// File: rtl/hazard_unit_mp.sv
// Pipeline hazard unit: multi-port forwarding, load-use and PC hazards,
// multi-cycle execute freeze and a saturating stall-cycle counter.
module hazard_unit_mp
    import hazard_unit_mp_pkg::*;
#(
    parameter int unsigned NSRC         = NSRC_DEF,
    parameter int unsigned NWP          = NWP_DEF,
    parameter int unsigned FWD_W        = FWD_W_DEF,
    parameter int unsigned MC_LAT       = MC_LAT_DEF,
    parameter int unsigned USE_EXT_DONE = USE_EXT_DONE_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NSRC*NWP-1:0]     match_e_m_i,
    input  logic [NSRC*NWP-1:0]     match_e_w_i,
    input  logic [NWP-1:0]          reg_write_m_i,
    input  logic [NWP-1:0]          reg_write_w_i,
    input  logic [NSRC-1:0]         match_d_e_i,
    input  logic                    mem_to_reg_e_i,
    input  logic                    pcsrc_d_i,
    input  logic                    pcsrc_e_i,
    input  logic                    pcsrc_m_i,
    input  logic                    pcsrc_w_i,
    input  logic                    branch_taken_e_i,
    input  logic                    mc_start_e_i,
    input  logic                    mc_done_i,
    output logic [NSRC*FWD_W-1:0]   forward_e_o,
    output logic                    stall_f_o,
    output logic                    stall_d_o,
    output logic                    stall_e_o,
    output logic                    flush_d_o,
    output logic                    flush_e_o,
    output logic                    bubble_m_o,
    output logic                    mc_busy_o,
    output logic [CNT_W-1:0]        stall_count_o
);

    logic             ldstall, pcwr, mc_start, busy_stall;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // W candidates first, then M overrides; descending p leaves lowest p last
    for (genvar s = 0; s < NSRC; s++) begin : g_fwd
        logic [FWD_W-1:0] sel;
        always_comb begin
            sel = FWD_W'(FWD_RF);
            for (int p = NWP - 1; p >= 0; p--) begin
                if (match_e_w_i[s*NWP+p] && reg_write_w_i[p]) sel = FWD_W'(fwd_w_sel(p));
            end
            for (int p = NWP - 1; p >= 0; p--) begin
                if (match_e_m_i[s*NWP+p] && reg_write_m_i[p]) sel = FWD_W'(fwd_m_sel(p));
            end
        end
        assign forward_e_o[s*FWD_W +: FWD_W] = sel;
    end

    assign ldstall  = mem_to_reg_e_i & (|match_d_e_i);
    assign pcwr     = pcsrc_d_i | pcsrc_e_i | pcsrc_m_i;
    assign mc_start = mc_start_e_i & ~branch_taken_e_i & ~ldstall;

    mc_busy_fsm #(
        .MC_LAT       (MC_LAT),
        .USE_EXT_DONE (USE_EXT_DONE)
    ) u_mc_busy_fsm (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (mc_start),
        .mc_done_i    (mc_done_i),
        .busy_stall_o (busy_stall),
        .bubble_m_o   (bubble_m_o),
        .mc_busy_o    (mc_busy_o)
    );

    assign stall_f_o = ldstall | pcwr | busy_stall;
    assign stall_d_o = ldstall | busy_stall;
    assign stall_e_o = busy_stall;
    assign flush_d_o = pcwr | pcsrc_w_i | branch_taken_e_i;
    // E holds the multi-cycle instruction while busy, so it is never flushed then
    assign flush_e_o = (ldstall | branch_taken_e_i) & ~busy_stall;

    assign stall_count_d = (stall_f_o && (stall_count_q != '1)) ? stall_count_q + 1'b1
                                                                  : stall_count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) stall_count_q <= '0;
        else         stall_count_q <= stall_count_d;
    end

    assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_hazard_unit_mp.sv
// Bench for hazard_unit_mp: an internal-latency instance and an external-done
// instance with a narrow counter share all stimulus except mc_start/mc_done.
module tb_hazard_unit_mp;

    logic clk_i = 1'b0;
    logic reset_i;
    logic [7:0] match_e_m, match_e_w;
    logic [1:0] rw_m, rw_w;
    logic [3:0] match_d_e;
    logic ld, pd, pe, pm, pw, br, st, st_x, done_x;

    logic [11:0] fwd, fwd_x;
    logic sf, sd, se, fd, fe, bm, busy;
    logic sf_x, sd_x, se_x, fd_x, fe_x, bm_x, busy_x;
    logic [15:0] cnt;
    logic [2:0]  cnt_x;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_cnt;
    logic [2:0]  exp_cnt_x;

    always #5 clk_i = ~clk_i;

    hazard_unit_mp #(.MC_LAT(4), .USE_EXT_DONE(0), .CNT_W(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .match_e_m_i(match_e_m), .match_e_w_i(match_e_w),
        .reg_write_m_i(rw_m), .reg_write_w_i(rw_w), .match_d_e_i(match_d_e),
        .mem_to_reg_e_i(ld), .pcsrc_d_i(pd), .pcsrc_e_i(pe), .pcsrc_m_i(pm),
        .pcsrc_w_i(pw), .branch_taken_e_i(br), .mc_start_e_i(st), .mc_done_i(1'b0),
        .forward_e_o(fwd), .stall_f_o(sf), .stall_d_o(sd), .stall_e_o(se),
        .flush_d_o(fd), .flush_e_o(fe), .bubble_m_o(bm), .mc_busy_o(busy),
        .stall_count_o(cnt)
    );

    hazard_unit_mp #(.MC_LAT(4), .USE_EXT_DONE(1), .CNT_W(3)) dut_x (
        .clk_i(clk_i), .reset_i(reset_i),
        .match_e_m_i(match_e_m), .match_e_w_i(match_e_w),
        .reg_write_m_i(rw_m), .reg_write_w_i(rw_w), .match_d_e_i(match_d_e),
        .mem_to_reg_e_i(ld), .pcsrc_d_i(pd), .pcsrc_e_i(pe), .pcsrc_m_i(pm),
        .pcsrc_w_i(pw), .branch_taken_e_i(br), .mc_start_e_i(st_x), .mc_done_i(done_x),
        .forward_e_o(fwd_x), .stall_f_o(sf_x), .stall_d_o(sd_x), .stall_e_o(se_x),
        .flush_d_o(fd_x), .flush_e_o(fe_x), .bubble_m_o(bm_x), .mc_busy_o(busy_x),
        .stall_count_o(cnt_x)
    );

    // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m}
    typedef struct {
        logic [11:0] fwd;
        logic [5:0]  ctl;
        logic        busy;
        logic [5:0]  ctlx;
        logic        busyx;
    } exp_t;

    typedef struct {
        logic [7:0]  mem;
        logic [7:0]  mw;
        logic [1:0]  rwm;
        logic [1:0]  rww;
        logic [3:0]  mde;
        logic        ld;
        logic [3:0]  pc;   // {d, e, m, w}
        logic        br;
        logic        st;
        logic [11:0] fwd;
        logic [5:0]  ctl;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    localparam logic [5:0] CTL_BUSY = 6'b111001;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t mk(input logic [5:0] ctl, input logic b,
                                input logic [5:0] ctlx, input logic bx);
        exp_t e;
        e.fwd = '0; e.ctl = ctl; e.busy = b; e.ctlx = ctlx; e.busyx = bx;
        return e;
    endfunction

    task automatic clear_inputs();
        match_e_m = '0; match_e_w = '0; rw_m = '0; rw_w = '0; match_d_e = '0;
        ld = 0; pd = 0; pe = 0; pm = 0; pw = 0; br = 0; st = 0; st_x = 0; done_x = 0;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_fwd"}, fwd, e.fwd);
        chk({tag, "_fwd_x"}, fwd_x, e.fwd);
        chk({tag, "_ctl"}, {sf, sd, se, fd, fe, bm}, e.ctl);
        chk({tag, "_busy"}, busy, e.busy);
        chk({tag, "_ctl_x"}, {sf_x, sd_x, se_x, fd_x, fe_x, bm_x}, e.ctlx);
        chk({tag, "_busy_x"}, busy_x, e.busyx);
        chk({tag, "_cnt"}, cnt, exp_cnt);
        chk({tag, "_cnt_x"}, cnt_x, exp_cnt_x);
        if (e.ctl[5] && exp_cnt != 16'hffff) exp_cnt++;
        if (e.ctlx[5] && exp_cnt_x != 3'd7) exp_cnt_x++;
    endtask

    task automatic step(input string tag, input exp_t e);
        sb.push_back(e);
        @(negedge clk_i);
        check_out(tag);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, "_ctl"}, {sf, sd, se, fd, fe, bm}, 6'b0);
        chk({tag, "_ctl_x"}, {sf_x, sd_x, se_x, fd_x, fe_x, bm_x}, 6'b0);
        chk({tag, "_busy"}, {busy, busy_x}, 2'b0);
        chk({tag, "_cnt"}, cnt, 16'd0);
        chk({tag, "_cnt_x"}, cnt_x, 3'd0);
    endtask

    initial begin
        exp_t e;
        clear_inputs();
        reset_i = 1'b1;
        exp_cnt = '0;
        exp_cnt_x = '0;

        //           mem     mw      rwm    rww    mde      ld  pc       br st fwd      ctl
        vecs[0] = '{8'h02, 8'h01, 2'b11, 2'b11, 4'b0000, 0, 4'b0000, 0, 0, 12'h003, 6'b000000};
        vecs[1] = '{8'h02, 8'h01, 2'b00, 2'b11, 4'b0000, 0, 4'b0000, 0, 0, 12'h002, 6'b000000};
        vecs[2] = '{8'h00, 8'h00, 2'b00, 2'b00, 4'b0000, 0, 4'b0000, 0, 0, 12'h000, 6'b000000};
        vecs[3] = '{8'h0C, 8'h80, 2'b11, 2'b10, 4'b0000, 0, 4'b0000, 0, 0, 12'h808, 6'b000000};
        vecs[4] = '{8'h20, 8'h20, 2'b01, 2'b11, 4'b0000, 0, 4'b0000, 0, 0, 12'h100, 6'b000000};
        vecs[5] = '{8'h00, 8'h00, 2'b00, 2'b00, 4'b0010, 1, 4'b0000, 0, 1, 12'h000, 6'b110010};
        vecs[6] = '{8'h00, 8'h00, 2'b00, 2'b00, 4'b0000, 1, 4'b0000, 0, 0, 12'h000, 6'b000000};
        vecs[7] = '{8'h00, 8'h00, 2'b00, 2'b00, 4'b0000, 0, 4'b0000, 1, 1, 12'h000, 6'b000110};
        vecs[8] = '{8'h00, 8'h00, 2'b00, 2'b00, 4'b0000, 0, 4'b0001, 0, 0, 12'h000, 6'b000100};
        vecs[9] = '{8'h00, 8'h00, 2'b00, 2'b00, 4'b0000, 0, 4'b0100, 0, 0, 12'h000, 6'b100100};

        #3;
        check_reset_now("reset_init");
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Combinational vectors; the FSM must stay idle throughout
        for (int i = 0; i < 10; i++) begin
            match_e_m = vecs[i].mem; match_e_w = vecs[i].mw;
            rw_m = vecs[i].rwm; rw_w = vecs[i].rww; match_d_e = vecs[i].mde;
            ld = vecs[i].ld; {pd, pe, pm, pw} = vecs[i].pc; br = vecs[i].br; st = vecs[i].st;
            e = mk(vecs[i].ctl, 1'b0, vecs[i].ctl, 1'b0);
            e.fwd = vecs[i].fwd;
            step($sformatf("vec%0d", i), e);
        end
        clear_inputs();
        step("vec_idle", mk(6'b0, 1'b0, 6'b0, 1'b0));

        // PC-writing instruction walking D -> E -> M -> W
        pd = 1; step("pc_d", mk(6'b100100, 0, 6'b100100, 0)); pd = 0;
        pe = 1; step("pc_e", mk(6'b100100, 0, 6'b100100, 0)); pe = 0;
        pm = 1; step("pc_m", mk(6'b100100, 0, 6'b100100, 0)); pm = 0;
        pw = 1; step("pc_w", mk(6'b000100, 0, 6'b000100, 0)); pw = 0;
        step("pc_done", mk(6'b0, 0, 6'b0, 0));

        // Internal latency: 3 BUSY cycles, one LAST; pcsrc_w flush honoured mid-op
        st = 1; step("mc_start", mk(6'b0, 0, 6'b0, 0)); st = 0;
        step("mc_b1", mk(CTL_BUSY, 1, 6'b0, 0));
        pw = 1; step("mc_b2_pcw", mk(CTL_BUSY | 6'b000100, 1, 6'b000100, 0)); pw = 0;
        st = 1; step("mc_b3", mk(CTL_BUSY, 1, 6'b0, 0));
        step("mc_last", mk(6'b0, 1, 6'b0, 0)); st = 0;
        step("mc_idle", mk(6'b0, 0, 6'b0, 0));

        // External completion after 7 BUSY cycles
        st_x = 1; step("x_start", mk(6'b0, 0, 6'b0, 0)); st_x = 0;
        for (int k = 1; k <= 7; k++) begin
            done_x = (k == 7);
            step($sformatf("x_b%0d", k), mk(6'b0, 0, CTL_BUSY, 1));
        end
        done_x = 0;
        step("x_last", mk(6'b0, 0, 6'b0, 1));
        step("x_idle", mk(6'b0, 0, 6'b0, 0));

        // Asynchronous reset in the second BUSY cycle
        st = 1; step("rst_start", mk(6'b0, 0, 6'b0, 0)); st = 0;
        step("rst_b1", mk(CTL_BUSY, 1, 6'b0, 0));
        #2;
        reset_i = 1'b1;
        exp_cnt = '0;
        exp_cnt_x = '0;
        #1;
        check_reset_now("reset_mid_busy");
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 3; k++) step($sformatf("post_rst%0d", k), mk(6'b0, 0, 6'b0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_unit_mp.md
Name: hazard_unit_mp

Overview:
- Parametrised successor to the pipeline hazard unit of the 5-stage ARM core (F/D/E/M/W).
- Generalises forwarding to NSRC source operands and NWP write ports per stage.
- Adds a multi-cycle execute-unit (MUL/DIV) busy FSM that freezes F/D/E and bubbles M.
- Adds a saturating stall-cycle performance counter. Sits beside controller/datapath; drives forwarding muxes and stage enables.

Parameters:
- NSRC, 4, number of E-stage source operands (A,B,C,D).
- NWP, 2, register-file write ports per stage (port0 = Rd result, port1 = base writeback / RdHi).
- FWD_W, 3, forward-select width per operand; must satisfy 2^FWD_W >= 2*NWP+1.
- MC_LAT, 4, multi-cycle op latency in cycles (>=2), used when USE_EXT_DONE=0.
- USE_EXT_DONE, 0, 1 = completion by mc_done only; 0 = internal counter only.
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- match_e_m  in  NSRC*NWP  bit [s*NWP+p]: E source s equals M write-port p destination
- match_e_w  in  NSRC*NWP  same, against W-stage destinations
- reg_write_m  in  NWP  M-stage write enables per port
- reg_write_w  in  NWP  W-stage write enables per port
- match_d_e  in  NSRC  D source s equals E port0 destination
- mem_to_reg_e  in  1  E instruction is a load
- pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w  in  1 each  PC-writing instruction in that stage
- branch_taken_e  in  1  branch resolved taken in E
- mc_start_e  in  1  condition-qualified multi-cycle op in E
- mc_done  in  1  external completion strobe
- forward_e  out  NSRC*FWD_W  per-operand select
- stall_f, stall_d, stall_e  out  1 each  hold stage register
- flush_d, flush_e  out  1 each  clear stage register
- bubble_m  out  1  insert NOP into M
- mc_busy  out  1  FSM not IDLE
- stall_count  out  CNT_W  cycles with stall_f=1, saturating

Behaviour:
- Reset (async, any time incl. mid multi-cycle op): FSM -> IDLE, counter=0, stall_count=0. All registered outputs 0; combinational outputs settle to their input-driven values.
- Forwarding (combinational), per operand s:
  - 0 = register file.
  - 1+2p = M port p, when match_e_m[s,p] & reg_write_m[p].
  - 2+2p = W port p, when match_e_w[s,p] & reg_write_w[p].
  - Priority: any M match over any W match; within a stage, lowest p wins.
- Load-use: ldstall = mem_to_reg_e & |match_d_e. Gives stall_f = stall_d = 1 and flush_e = 1 in the same cycle.
- PC hazard: pcwr = pcsrc_d|pcsrc_e|pcsrc_m.
  - stall_f |= pcwr.
  - flush_d = pcwr | pcsrc_w | branch_taken_e.
  - flush_e |= branch_taken_e.
- FSM states IDLE, BUSY, LAST:
  - IDLE -> BUSY on mc_start_e & ~branch_taken_e & ~ldstall; load counter MC_LAT-2.
  - BUSY: stall_f = stall_d = stall_e = 1, bubble_m = 1, flush_e = 0 (E instruction held). Counter decrements each cycle.
  - BUSY -> LAST when done: counter==0 (USE_EXT_DONE=0) or mc_done (USE_EXT_DONE=1).
  - LAST: one cycle, no stalls; the E result advances to M. Then LAST -> IDLE.
  - A new mc_start_e in LAST is ignored, since it is still the same instruction.
- Simultaneous events:
  - branch_taken_e with mc_start_e: branch wins, no BUSY entry.
  - ldstall with mc_start_e: ldstall wins; mc_start_e is re-evaluated next cycle.
  - In BUSY, flush_d from pcsrc_w is still honoured. stall_f remains 1.
- mc_busy = (state != IDLE). Only BUSY asserts stalls.
- stall_count increments on every cycle with stall_f=1 and holds at 2^CNT_W-1.

Decomposition:
- Shared package holds:
  - forward encoding constants: FWD_RF=0, FWD_M(p)=1+2p, FWD_W(p)=2+2p;
  - FSM state enum (2-bit);
  - default parameter values.
- One sub-module, mc_busy_fsm: FSM, latency counter, completion mux; outputs busy_stall, bubble_m, mc_busy.
- The top holds forwarding priority logic (generate loop over NSRC), load-use and PC logic, and the perf counter.

Test Plan:
- Forwarding priority: match_e_m[s0]=port1, match_e_w[s0]=port0, all reg_write=1 -> forward s0 = 3 (M port1). Clear reg_write_m -> 2 (W port0). Clear all -> 0.
- Load-use: mem_to_reg_e=1, match_d_e=0b0010 -> stall_f=stall_d=flush_e=1 for exactly that cycle. mc_start_e also high -> mc_busy stays 0.
- Multi-cycle, MC_LAT=4, internal: mc_start_e pulse -> stall_e/bubble_m high exactly 3 cycles, then one LAST cycle without stall, mc_busy high 4 cycles. stall_count += 3.
- External done: USE_EXT_DONE=1, mc_done after 7 cycles -> stalls held 7 cycles, release the cycle after mc_done.
- Branch priority: branch_taken_e & mc_start_e same cycle -> flush_d=flush_e=1, mc_busy=0. pcsrc_d then pcsrc_e,m -> stall_f 3 cycles, flush_d 4 cycles (through pcsrc_w).
- Reset mid-BUSY (cycle 2): all stalls 0 and stall_count=0 immediately (async). After release, FSM in IDLE and stalls stay 0 with mc_start_e=0.
